conv_output_writer: RTL
=======================

Name: conv_output_writer

Overview:
- Downstream stage of the convolution controller and compute unit. Consumes one PP_PAR-lane accumulator vector per output strip, qualified by the controller's dout_valid, col_idx and row_idx.
- Applies per-lane bias, rounding right-shift, optional ReLU and int8 saturation.
- Buffers the results in a small FIFO and emits them on a ready/valid output stream with row and frame markers.
- The compute side has no backpressure, so the block drops on FIFO overflow and reports it with a sticky flag and a counter.

Parameters:
- PP_PAR, 8, number of parallel output lanes per strip
- ACC_W, 32, signed accumulator width per lane
- OUT_W, 8, signed output width per lane
- FIFO_DEPTH, 16, output FIFO entries (power of two, >= 4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  frame start pulse; clears counters, pipeline, FIFO and overflow status
- img_width_strips  in  16  strips per row (>= 1)
- img_height  in  16  rows per frame (>= 1)
- shift_amt  in  5  requant right-shift, 0..31
- relu_en  in  1  clamp negatives to 0
- bias  in  PP_PAR*ACC_W  per-lane signed bias, static during a frame
- acc_valid  in  1  accumulator vector valid (the controller's dout_valid)
- acc_data  in  PP_PAR*ACC_W  per-lane signed accumulators, lane 0 in the LSBs
- col_idx  in  16  strip column of acc_data
- row_idx  in  16  row of acc_data
- out_valid  out  1  output vector valid
- out_ready  in  1  consumer ready
- out_data  out  PP_PAR*OUT_W  packed int8 lanes, lane 0 in the LSBs
- out_last_row  out  1  vector is the last strip of its row
- out_last_frame  out  1  vector is the last strip of the frame
- frame_done  out  1  one-cycle pulse when the last_frame vector is accepted
- overflow  out  1  sticky; at least one vector was dropped
- drop_count  out  16  number of dropped vectors, saturating at 0xFFFF

Behaviour:
- Reset: all outputs are 0, the FIFO is empty and the pipeline is empty. Reset overrides start. Reset or start mid-frame discards all in-flight and buffered data.
- Start while idle or running: takes effect on the next edge, with the same clearing effect as reset except that the cfg inputs are sampled live.
- Stage S1 (registered on acc_valid):
  - sum = sext(acc) + sext(bias) + rnd, computed in ACC_W+2 signed bits per lane.
  - rnd = (shift_amt == 0) ? 0 : 1 << (shift_amt - 1).
  - Tags are captured in S1: last_row = (col_idx == img_width_strips-1); last_frame = last_row && (row_idx == img_height-1).
- Stage S2:
  - v = sum >>> shift_amt (arithmetic shift).
  - If relu_en and v < 0, then v = 0.
  - Saturate v to [-128, 127].
  - S2 pushes {data, last_row, last_frame} into the FIFO.
- Latency: acc_valid at edge t gives a FIFO write at edge t+2. With the FIFO empty, out_valid is high after edge t+3.
- The pipeline never stalls; acc_valid is accepted every cycle (back-to-back allowed).
- FIFO push:
  - When the FIFO is full and there is no pop in the same cycle, the vector is dropped: overflow is set, drop_count increments, and FIFO contents are unchanged.
  - When the FIFO is full and a pop occurs in the same cycle, the push succeeds and the count is unchanged.
  - Push and pop on an empty FIFO: the pushed vector becomes visible on the next cycle (no fall-through).
- Output handshake:
  - A transfer happens when out_valid && out_ready.
  - out_data and the tags are held stable while out_valid && !out_ready.
  - out_valid never deasserts without a transfer, except on rst or start.
- frame_done pulses in the cycle after a transfer with out_last_frame = 1.
- Overflow and drop_count clear only on rst or start.
- Wrap: FIFO pointers are log2(FIFO_DEPTH)+1 bits. Full means the MSBs differ and the lower bits are equal; empty means the pointers are equal.
- Indices are not checked for order; tags derive purely from col_idx and row_idx.

Test Plan:
- Single lane path, shift_amt=4, bias=0, relu_en=0: acc=100 → out=6 (100+8=108, >>4); acc=-100 → out=-6 (-92>>>4); acc=10000 → out=127; acc=-10000 → out=-128.
- relu_en=1, bias=-50, shift_amt=0: acc=30 → 0; acc=80 → 30. All 8 lanes use distinct values and the lane ordering is checked.
- img_width_strips=3, img_height=2, out_ready=1, six acc_valid pulses: out_last_row on outputs 3 and 6; out_last_frame and frame_done only on output 6. The first output is valid 3 cycles after the first acc_valid.
- out_ready=0 with 20 back-to-back acc_valid, FIFO_DEPTH=16: 16 stored, overflow=1, drop_count=4. Then out_ready=1 drains exactly the first 16 vectors in order, with data stable while stalled.
- FIFO full with out_ready=1 and a simultaneous push: no drop, count stays 16, order is preserved.
- start asserted mid-frame with 5 entries buffered: the next cycle has out_valid=0, overflow=0 and drop_count=0. A new frame then outputs correctly with no stale data.

Source files
------------

// File: rtl/conv_output_writer.sv
// Output stage of the convolution pipeline: bias, rounding shift, ReLU and int8 saturation per lane,
// then a drop-on-overflow FIFO feeding a ready/valid stream tagged with row and frame markers.

module conv_ow_lane #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld1,
  input  logic             ld2,
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] bias,
  input  logic [ACC_W+1:0] rnd,
  input  logic [4:0]       shift,
  input  logic             relu,
  output logic [OUT_W-1:0] q
);
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] MAXV = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = ~MAXV;

  logic signed [SW-1:0] sum_d, sum_q, v;
  logic [OUT_W-1:0]     q_d;

  assign sum_d = $signed({{2{acc[ACC_W-1]}}, acc}) + $signed({{2{bias[ACC_W-1]}}, bias})
               + $signed(rnd);

  always_comb begin
    v = sum_q >>> shift;
    if (relu && v[SW-1]) v = '0;
    if (v > MAXV)      q_d = MAXV[OUT_W-1:0];
    else if (v < MINV) q_d = MINV[OUT_W-1:0];
    else               q_d = v[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sum_q <= '0;
      q     <= '0;
    end else begin
      if (ld1) sum_q <= sum_d;
      if (ld2) q     <= q_d;
    end
  end
endmodule

module conv_output_writer #(
  parameter int PP_PAR     = 8,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             img_width_strips,
  input  logic [15:0]             img_height,
  input  logic [4:0]              shift_amt,
  input  logic                    relu_en,
  input  logic [PP_PAR*ACC_W-1:0] bias,
  input  logic                    acc_valid,
  input  logic [PP_PAR*ACC_W-1:0] acc_data,
  input  logic [15:0]             col_idx,
  input  logic [15:0]             row_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PP_PAR*OUT_W-1:0] out_data,
  output logic                    out_last_row,
  output logic                    out_last_frame,
  output logic                    frame_done,
  output logic                    overflow,
  output logic [15:0]             drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = PP_PAR*OUT_W + 2;
  localparam logic [ACC_W+1:0] ONE = 1;

  logic                         clr;
  logic [2:1]                   vld_pipe;
  logic [4:0]                   s1_shift;
  logic                         s1_relu, s1_lr, s1_lf, s2_lr, s2_lf;
  logic [PP_PAR-1:0][OUT_W-1:0] s2_q;
  logic [ACC_W+1:0]             rnd;
  logic                         last_row, last_frame;

  assign clr        = rst | start;
  assign rnd        = (shift_amt == 5'd0) ? '0 : ONE << (shift_amt - 5'd1);
  assign last_row   = (col_idx == img_width_strips - 16'd1);
  assign last_frame = last_row && (row_idx == img_height - 16'd1);

  for (genvar i = 0; i < PP_PAR; i++) begin : g_lane
    conv_ow_lane #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_lane (
      .clk   (clk),
      .clr   (clr),
      .ld1   (acc_valid),
      .ld2   (vld_pipe[1]),
      .acc   (acc_data[i*ACC_W +: ACC_W]),
      .bias  (bias[i*ACC_W +: ACC_W]),
      .rnd   (rnd),
      .shift (s1_shift),
      .relu  (s1_relu),
      .q     (s2_q[i])
    );
  end

  // FIFO; vis_ptr lags wr_ptr by a cycle so a freshly written entry is never presented the same cycle.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, vis_ptr;
  logic [EW-1:0] head;
  logic          full, push, pop;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid = (rd_ptr != vis_ptr);
  assign pop       = out_valid && out_ready;
  assign push      = vld_pipe[2] && (!full || pop);
  assign head      = mem[rd_ptr[AW-1:0]];

  assign out_data       = out_valid ? head[EW-1:2] : '0;
  assign out_last_row   = out_valid && head[1];
  assign out_last_frame = out_valid && head[0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s2_q, s2_lr, s2_lf};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe   <= '0;
      s1_shift   <= '0;
      s1_relu    <= 1'b0;
      s1_lr      <= 1'b0;
      s1_lf      <= 1'b0;
      s2_lr      <= 1'b0;
      s2_lf      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      vis_ptr    <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], acc_valid};
      if (acc_valid) begin
        s1_shift <= shift_amt;
        s1_relu  <= relu_en;
        s1_lr    <= last_row;
        s1_lf    <= last_frame;
      end
      if (vld_pipe[1]) begin
        s2_lr <= s1_lr;
        s2_lf <= s1_lf;
      end
      wr_ptr     <= wr_ptr + {{AW{1'b0}}, push};
      rd_ptr     <= rd_ptr + {{AW{1'b0}}, pop};
      vis_ptr    <= wr_ptr;
      frame_done <= pop && out_last_frame;
      if (vld_pipe[2] && full && !pop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end
endmodule
